// File: rtl/rggen_rtl_pkg.sv
// Shared register-block types plus the host arbiter's state type and
// rotate-and-pick helper.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_WRITE        = 2'b11
    } rggen_access;

    localparam int unsigned RGGEN_ACCESS_DATA_BIT = 0;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic {
        IDLE,
        BUSY
    } rggen_host_arbiter_state;

    // Widest request vector the picker helper handles.
    localparam int unsigned RGGEN_RR_MAX_ENTRIES = 32;

    // One-hot of the first set request at or above pointer, wrapping at entries.
    // pointer must be below entries.
    function automatic logic [RGGEN_RR_MAX_ENTRIES-1:0] rggen_rr_pick(
        input logic [RGGEN_RR_MAX_ENTRIES-1:0] request,
        input int unsigned                     entries,
        input int unsigned                     pointer
    );
        logic [RGGEN_RR_MAX_ENTRIES-1:0] grant;
        logic                            found;
        int unsigned                     position;
        logic [4:0]                      slot;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < RGGEN_RR_MAX_ENTRIES; i++) begin
            position = pointer + i;
            if (position >= entries) begin
                position = position - entries;
            end
            slot = position[4:0];
            if ((i < entries) && !found && request[slot]) begin
                grant[slot] = 1'b1;
                found       = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/rggen_mux.sv
// One-hot AND-OR multiplexer; an all-zero select yields zero.
module rggen_mux #(
    parameter int WIDTH   = 2,
    parameter int ENTRIES = 2
)(
    input  logic [ENTRIES-1:0]            i_select,
    input  logic [ENTRIES-1:0][WIDTH-1:0] i_data,
    output logic [WIDTH-1:0]              o_data
);

    // OR together every entry whose select bit is set.
    always_comb begin
        o_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            o_data = o_data | (i_data[i] & {WIDTH{i_select[i]}});
        end
    end

endmodule

// File: rtl/rggen_round_robin_picker.sv
// Combinational round-robin picker: first request at or above the pointer wins.
module rggen_round_robin_picker
    import rggen_rtl_pkg::*;
#(
    parameter int ENTRIES     = 2,
    parameter int INDEX_WIDTH = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
)(
    input  logic [ENTRIES-1:0]     i_request,
    input  logic [INDEX_WIDTH-1:0] i_pointer,
    output logic [ENTRIES-1:0]     o_grant,
    output logic [INDEX_WIDTH-1:0] o_index
);

    logic [RGGEN_RR_MAX_ENTRIES-1:0] request_ext;
    logic [RGGEN_RR_MAX_ENTRIES-1:0] grant_ext;
    logic                            unused_grant_ext;

    // Widen to the helper's fixed width, pick, then encode the one-hot result.
    always_comb begin
        request_ext                = '0;
        request_ext[ENTRIES-1:0]   = i_request;
        grant_ext                  = rggen_rr_pick(request_ext, ENTRIES, 32'(i_pointer));
        o_grant                    = grant_ext[ENTRIES-1:0];
        o_index                    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (o_grant[i]) begin
                o_index = INDEX_WIDTH'(i);
            end
        end
    end

    // Bits above ENTRIES are always zero.
    assign unused_grant_ext = ^grant_ext;

endmodule

// File: rtl/rggen_host_arbiter.sv
// Round-robin arbiter sharing one register-block host bus among HOSTS requesters.
// A granted host owns the bus from valid until ready; steering is combinational
// from the registered one-hot grant, which is zero whenever the FSM is idle.
module rggen_host_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int HOSTS         = 2,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
)(
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [HOSTS-1:0]                    i_host_valid,
    input  rggen_access [HOSTS-1:0]             i_host_access,
    input  logic [HOSTS-1:0][ADDRESS_WIDTH-1:0] i_host_address,
    input  logic [HOSTS-1:0][BUS_WIDTH-1:0]     i_host_write_data,
    input  logic [HOSTS-1:0][BUS_WIDTH-1:0]     i_host_strobe,
    output logic [HOSTS-1:0]                    o_host_ready,
    output rggen_status                         o_host_status,
    output logic [BUS_WIDTH-1:0]                o_host_read_data,
    output logic                                o_valid,
    output rggen_access                         o_access,
    output logic [ADDRESS_WIDTH-1:0]            o_address,
    output logic [BUS_WIDTH-1:0]                o_write_data,
    output logic [BUS_WIDTH-1:0]                o_strobe,
    input  logic                                i_ready,
    input  rggen_status                         i_status,
    input  logic [BUS_WIDTH-1:0]                i_read_data,
    output logic [HOSTS-1:0]                    o_grant
);

    localparam int INDEX_WIDTH  = (HOSTS > 1) ? $clog2(HOSTS) : 1;
    localparam int ACCESS_WIDTH = $bits(rggen_access);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(HOSTS - 1);

    rggen_host_arbiter_state state_q;
    logic [INDEX_WIDTH-1:0]  grant_q;
    logic [HOSTS-1:0]        grant_onehot_q;
    logic [INDEX_WIDTH-1:0]  ptr_q;

    logic [HOSTS-1:0]        pick_grant;
    logic [INDEX_WIDTH-1:0]  pick_index;
    logic [INDEX_WIDTH-1:0]  next_ptr;
    logic                    owner_valid;
    logic                    busy;

    logic [HOSTS-1:0][ACCESS_WIDTH-1:0] host_access;
    logic [ACCESS_WIDTH-1:0]            access;

    rggen_round_robin_picker #(
        .ENTRIES     (HOSTS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_picker (
        .i_request (i_host_valid),
        .i_pointer (ptr_q),
        .o_grant   (pick_grant),
        .o_index   (pick_index)
    );

    assign busy        = (state_q == BUSY);
    assign owner_valid = |(grant_onehot_q & i_host_valid);
    assign next_ptr    = (grant_q == LAST_INDEX) ? '0 : grant_q + INDEX_WIDTH'(1);

    // Arbitration FSM: lock a host in IDLE, release on completion or abandon.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            grant_onehot_q <= '0;
            ptr_q          <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|i_host_valid) begin
                        state_q        <= BUSY;
                        grant_q        <= pick_index;
                        grant_onehot_q <= pick_grant;
                    end
                end
                BUSY: begin
                    if (!owner_valid) begin
                        // Host withdrew mid-transaction: keep its priority slot.
                        state_q        <= IDLE;
                        grant_onehot_q <= '0;
                    end else if (i_ready) begin
                        state_q        <= IDLE;
                        grant_onehot_q <= '0;
                        ptr_q          <= next_ptr;
                    end
                end
            endcase
        end
    end

    assign host_access = i_host_access;

    rggen_mux #(
        .WIDTH   (ACCESS_WIDTH),
        .ENTRIES (HOSTS)
    ) u_access_mux (
        .i_select (grant_onehot_q),
        .i_data   (host_access),
        .o_data   (access)
    );

    rggen_mux #(
        .WIDTH   (ADDRESS_WIDTH),
        .ENTRIES (HOSTS)
    ) u_address_mux (
        .i_select (grant_onehot_q),
        .i_data   (i_host_address),
        .o_data   (o_address)
    );

    rggen_mux #(
        .WIDTH   (BUS_WIDTH),
        .ENTRIES (HOSTS)
    ) u_write_data_mux (
        .i_select (grant_onehot_q),
        .i_data   (i_host_write_data),
        .o_data   (o_write_data)
    );

    rggen_mux #(
        .WIDTH   (BUS_WIDTH),
        .ENTRIES (HOSTS)
    ) u_strobe_mux (
        .i_select (grant_onehot_q),
        .i_data   (i_host_strobe),
        .o_data   (o_strobe)
    );

    // Request qualifier and response routing back to the owner only.
    always_comb begin
        o_grant          = grant_onehot_q;
        o_valid          = owner_valid;
        o_access         = rggen_access'(access);
        o_host_ready     = grant_onehot_q & i_host_valid & {HOSTS{i_ready}};
        o_host_status    = busy ? i_status : RGGEN_OKAY;
        o_host_read_data = busy ? i_read_data : '0;
    end

endmodule

// File: tb/tb_rggen_host_arbiter.sv
// Self-checking bench for rggen_host_arbiter with three hosts.
module tb_rggen_host_arbiter;
    import rggen_rtl_pkg::*;

    localparam int H  = 3;
    localparam int AW = 8;
    localparam int BW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [H-1:0]          host_valid;
    rggen_access [H-1:0]   host_access;
    logic [H-1:0][AW-1:0]  host_address;
    logic [H-1:0][BW-1:0]  host_write_data;
    logic [H-1:0][BW-1:0]  host_strobe;
    logic [H-1:0]          host_ready;
    rggen_status           host_status;
    logic [BW-1:0]         host_read_data;
    logic                  valid;
    rggen_access           access;
    logic [AW-1:0]         address;
    logic [BW-1:0]         write_data;
    logic [BW-1:0]         strobe;
    logic                  ready;
    rggen_status           status;
    logic [BW-1:0]         read_data;
    logic [H-1:0]          grant;

    int checks = 0;
    int errors = 0;

    rggen_host_arbiter #(
        .HOSTS         (H),
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (BW)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_host_valid      (host_valid),
        .i_host_access     (host_access),
        .i_host_address    (host_address),
        .i_host_write_data (host_write_data),
        .i_host_strobe     (host_strobe),
        .o_host_ready      (host_ready),
        .o_host_status     (host_status),
        .o_host_read_data  (host_read_data),
        .o_valid           (valid),
        .o_access          (access),
        .o_address         (address),
        .o_write_data      (write_data),
        .o_strobe          (strobe),
        .i_ready           (ready),
        .i_status          (status),
        .i_read_data       (read_data),
        .o_grant           (grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        host_valid      = '0;
        for (int h = 0; h < H; h++) host_access[h] = RGGEN_READ;
        host_address    = '0;
        host_write_data = '0;
        host_strobe     = '0;
        ready           = 1'b0;
        status          = RGGEN_OKAY;
        read_data       = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        host_valid = '1;
        host_address[0] = 8'h5A;
        ready = 1'b1;
        read_data = 32'h1234_5678;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset.valid got %b want 0", valid); end
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset.grant got %b want 000", grant); end
        checks++; if (host_ready !== 3'b000) begin errors++; $display("FAIL reset.ready got %b want 000", host_ready); end
        checks++; if (address !== 8'h00) begin errors++; $display("FAIL reset.address got %h want 00", address); end
        checks++; if (host_read_data !== 32'h0) begin errors++; $display("FAIL reset.rdata got %h want 0", host_read_data); end
        checks++; if (access !== rggen_access'(0)) begin errors++; $display("FAIL reset.access got %b want 00", access); end
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL reset.first_grant got %b want 001", grant); end
        checks++; if (address !== 8'h5A) begin errors++; $display("FAIL reset.first_addr got %h want 5a", address); end
    endtask

    task automatic test_single_write();
        apply_reset();
        tick();
        host_valid = 3'b010;
        host_access[1] = RGGEN_WRITE;
        host_address[1] = 8'h10;
        host_write_data[1] = 32'hA5A5_0000;
        host_strobe[1] = '1;
        ready = 1'b1;
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single.c0_valid got %b want 0", valid); end
        checks++; if (host_ready !== 3'b000) begin errors++; $display("FAIL single.c0_ready got %b want 000", host_ready); end
        tick();
        @(negedge clk);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single.c1_valid got %b want 1", valid); end
        checks++; if (access !== RGGEN_WRITE) begin errors++; $display("FAIL single.c1_access got %b want 11", access); end
        checks++; if (address !== 8'h10) begin errors++; $display("FAIL single.c1_addr got %h want 10", address); end
        checks++; if (write_data !== 32'hA5A5_0000) begin errors++; $display("FAIL single.c1_wdata got %h want a5a50000", write_data); end
        checks++; if (strobe !== 32'hFFFF_FFFF) begin errors++; $display("FAIL single.c1_strobe got %h want ffffffff", strobe); end
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL single.c1_grant got %b want 010", grant); end
        checks++; if (host_ready !== 3'b010) begin errors++; $display("FAIL single.c1_ready got %b want 010", host_ready); end
        tick();
        @(negedge clk);
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL single.c2_grant got %b want 000", grant); end
        checks++; if (host_ready !== 3'b000) begin errors++; $display("FAIL single.c2_ready got %b want 000", host_ready); end
        tick();
        @(negedge clk);
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL single.c3_grant got %b want 010", grant); end
    endtask

    task automatic test_contention();
        logic [H-1:0] exp;
        apply_reset();
        tick();
        host_valid = 3'b111;
        for (int h = 0; h < H; h++) host_address[h] = AW'(8'h30 + h);
        ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp = '0;
            if (c % 2 == 1) exp[((c - 1) / 2) % 3] = 1'b1;
            checks++; if (grant !== exp) begin errors++; $display("FAIL contention.grant c%0d got %b want %b", c, grant, exp); end
            checks++; if (host_ready !== exp) begin errors++; $display("FAIL contention.ready c%0d got %b want %b", c, host_ready, exp); end
            checks++; if (valid !== (exp != 0)) begin errors++; $display("FAIL contention.valid c%0d got %b want %b", c, valid, exp != 0); end
            tick();
        end
    endtask

    task automatic test_wait_states();
        apply_reset();
        tick();
        host_valid = 3'b101;
        host_access[0] = RGGEN_READ;
        host_address[0] = 8'h24;
        ready = 1'b0;
        status = RGGEN_SLAVE_ERROR;
        read_data = 32'hDEAD_BEEF;
        tick();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (grant !== 3'b001) begin errors++; $display("FAIL wait.grant c%0d got %b want 001", c, grant); end
            checks++; if (host_ready !== 3'b000) begin errors++; $display("FAIL wait.ready c%0d got %b want 000", c, host_ready); end
            tick();
        end
        ready = 1'b1;
        status = RGGEN_OKAY;
        @(negedge clk);
        checks++; if (host_ready !== 3'b001) begin errors++; $display("FAIL wait.done_ready got %b want 001", host_ready); end
        checks++; if (host_read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wait.rdata got %h want deadbeef", host_read_data); end
        checks++; if (host_status !== RGGEN_OKAY) begin errors++; $display("FAIL wait.status got %b want 00", host_status); end
        tick();
        host_valid = 3'b100;
        ready = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL wait.idle_grant got %b want 000", grant); end
        checks++; if (host_read_data !== 32'h0) begin errors++; $display("FAIL wait.idle_rdata got %h want 0", host_read_data); end
        tick();
        @(negedge clk);
        checks++; if (grant !== 3'b100) begin errors++; $display("FAIL wait.next_grant got %b want 100", grant); end
    endtask

    task automatic test_abandon();
        apply_reset();
        tick();
        host_valid = 3'b001;
        ready = 1'b1;
        tick();
        tick();
        host_valid = 3'b011;
        ready = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL abandon.grant got %b want 010", grant); end
        tick();
        host_valid = 3'b001;
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abandon.valid got %b want 0", valid); end
        tick();
        @(negedge clk);
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL abandon.idle_grant got %b want 000", grant); end
        tick();
        @(negedge clk);
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL abandon.regrant got %b want 001", grant); end
    endtask

    task automatic test_reset_mid_busy();
        apply_reset();
        tick();
        host_valid = 3'b010;
        ready = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL midrst.pre_grant got %b want 010", grant); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst.valid got %b want 0", valid); end
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL midrst.grant got %b want 000", grant); end
        @(negedge clk);
        rst_n = 1'b1;
        host_valid = 3'b011;
        tick();
        @(negedge clk);
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL midrst.restart got %b want 001", grant); end
    endtask

    // Random traffic checked against an owner/pointer model of the arbitration rules.
    task automatic test_random();
        int owner;
        int ptr;
        int completions;
        logic [H-1:0] done;
        logic [H-1:0] exp_grant;
        logic [H-1:0] exp_ready;
        logic exp_valid;
        logic [AW-1:0] exp_addr;
        logic [BW-1:0] exp_wdata;
        logic [BW-1:0] exp_strobe;
        logic [BW-1:0] exp_rdata;
        rggen_access exp_access;
        rggen_status exp_status;
        apply_reset();
        owner = -1;
        ptr = 0;
        completions = 0;
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            done = '0;
            if (owner < 0) begin
                for (int k = 0; k < H; k++) begin
                    if (owner < 0 && host_valid[(ptr + k) % H]) owner = (ptr + k) % H;
                end
            end else if (!host_valid[owner]) begin
                owner = -1;
            end else if (ready) begin
                done[owner] = 1'b1;
                completions++;
                ptr = (owner + 1) % H;
                owner = -1;
            end
            #1;
            for (int h = 0; h < H; h++) begin
                if ((host_valid[h] && done[h]) || (!host_valid[h] && $urandom_range(0, 2) == 0)) begin
                    host_valid[h] = !(host_valid[h] && $urandom_range(0, 1) == 0);
                    case ($urandom_range(0, 2))
                        0:       host_access[h] = RGGEN_READ;
                        1:       host_access[h] = RGGEN_WRITE;
                        default: host_access[h] = RGGEN_POSTED_WRITE;
                    endcase
                    host_address[h]    = AW'($urandom);
                    host_write_data[h] = $urandom;
                    host_strobe[h]     = $urandom;
                end else if (host_valid[h] && $urandom_range(0, 49) == 0) begin
                    host_valid[h] = 1'b0;
                end
            end
            ready     = ($urandom_range(0, 2) != 0);
            status    = rggen_status'($urandom_range(0, 3));
            read_data = $urandom;
            @(negedge clk);
            exp_grant  = '0;
            exp_ready  = '0;
            exp_valid  = 1'b0;
            exp_addr   = '0;
            exp_wdata  = '0;
            exp_strobe = '0;
            exp_rdata  = '0;
            exp_access = rggen_access'(0);
            exp_status = RGGEN_OKAY;
            if (owner >= 0) begin
                exp_grant[owner] = 1'b1;
                exp_ready[owner] = ready && host_valid[owner];
                exp_valid  = host_valid[owner];
                exp_addr   = host_address[owner];
                exp_wdata  = host_write_data[owner];
                exp_strobe = host_strobe[owner];
                exp_access = host_access[owner];
                exp_rdata  = read_data;
                exp_status = status;
            end
            checks++; if (grant !== exp_grant) begin errors++; $display("FAIL rand.grant n%0d got %b want %b", n, grant, exp_grant); end
            checks++; if (host_ready !== exp_ready) begin errors++; $display("FAIL rand.ready n%0d got %b want %b", n, host_ready, exp_ready); end
            checks++; if (valid !== exp_valid) begin errors++; $display("FAIL rand.valid n%0d got %b want %b", n, valid, exp_valid); end
            checks++; if (address !== exp_addr) begin errors++; $display("FAIL rand.addr n%0d got %h want %h", n, address, exp_addr); end
            checks++; if (write_data !== exp_wdata) begin errors++; $display("FAIL rand.wdata n%0d got %h want %h", n, write_data, exp_wdata); end
            checks++; if (strobe !== exp_strobe) begin errors++; $display("FAIL rand.strobe n%0d got %h want %h", n, strobe, exp_strobe); end
            checks++; if (access !== exp_access) begin errors++; $display("FAIL rand.access n%0d got %b want %b", n, access, exp_access); end
            checks++; if (host_read_data !== exp_rdata) begin errors++; $display("FAIL rand.rdata n%0d got %h want %h", n, host_read_data, exp_rdata); end
            checks++; if (host_status !== exp_status) begin errors++; $display("FAIL rand.status n%0d got %b want %b", n, host_status, exp_status); end
        end
        checks++; if (completions < 20) begin errors++; $display("FAIL rand.completions got %0d want at least 20", completions); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_wait_states();
        test_abandon();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
